sprite_compositor: RTL and testbench
====================================

SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

Interface
REQ-001 Parameter NUM_SPR, default 4: number of sprite channels; index 0 has the highest priority.
REQ-002 Parameter SPR_DIM, default 32: sprite width and height in pixels; SHALL be a power of 2.
REQ-003 Parameter COLOR_W, default 12: RGB444 pixel width.
REQ-004 Parameter TRANSP, default 12'h000: colour key; a sprite texel of this value is transparent.
REQ-005 Parameter BLINK_FRAMES, default 16: frames per blink phase.
REQ-006 clk  in  1  pixel-domain clock; one clock; all state on rising edge.
REQ-007 rst  in  1  reset; synchronous and active-high.
REQ-008 pix_en  in  1  pixel strobe; the pipeline advances only when it is high.
REQ-009 col_addr  in  10 / row_addr  in  9  current raster coordinate.
REQ-010 frame_start  in  1  one-cycle pulse at vblank start.
REQ-011 spr_x  in  NUM_SPR*10 / spr_y  in  NUM_SPR*9  sprite top-left positions, flat-packed with sprite i at slice i.
REQ-012 spr_en, spr_blink  in  NUM_SPR each  visibility enable and blink enable per sprite.
REQ-013 spr_rot  in  NUM_SPR*2  orientation per sprite.
REQ-014 is_wall, is_bean  in  1 each  background classification of the current coordinate.
REQ-015 over  in  1  game-over blanking.
REQ-016 rom_addr  out  NUM_SPR*log2(SPR_DIM^2)  texel address per sprite.
REQ-017 rom_data  in  NUM_SPR*COLOR_W  texel per sprite; synchronous ROM, one-cycle latency.
REQ-018 pix_color  out  COLOR_W  composited pixel.
REQ-019 pix_valid  out  1  pix_color corresponds to a coordinate presented 2 enabled cycles earlier.

Function
REQ-020 On frame_start, spr_x, spr_y, spr_en, spr_blink and spr_rot SHALL be latched into shadow registers; compositing SHALL use only the shadow registers, so mid-frame input changes have no effect.
REQ-021 Frame counter: SHALL count frame_start pulses from 0 to BLINK_FRAMES-1 and then wrap to 0, toggling blink_phase on each wrap.
REQ-022 Sprite i hit: shadow enable is 1, and not (blink set and blink_phase=1), and 0<=col-x<SPR_DIM, and 0<=row-y<SPR_DIM, with the subtractions computed 1 bit wider so no wrap-around occurs.
REQ-023 dx=col-x, dy=row-y; rom_addr: rot 00 = dx*SPR_DIM+dy; rot 01 = dx*SPR_DIM+(SPR_DIM-1-dy); rot 10 = dy*SPR_DIM+dx; rot 11 = dy*SPR_DIM+(SPR_DIM-1-dx).
REQ-024 Stage 1 (enabled edge): SHALL register rom_addr, the hit vector, is_wall, is_bean and over.
REQ-025 Stage 2 (next enabled edge): SHALL register pix_color using this priority: over gives 0; else is_wall gives 12'hfff; else the lowest-index hit sprite with rom_data!=TRANSP gives that rom_data; else is_bean gives 12'hff0; else 0.
REQ-026 A transparent texel SHALL fall through to the next hit sprite, then to the bean, then to black.
REQ-027 pix_valid SHALL rise after 2 enabled cycles following reset and then stay high; when pix_en=0, all pipeline registers hold.
REQ-028 When frame_start and pix_en coincide, the pixel in stage 0 SHALL use the old shadow values; the new values apply from the next pixel.
REQ-029 A sprite partially past col 639 or row 479 SHALL draw only its on-screen part, with no wrap to column or row 0.

Reset
REQ-030 On rst, shadow registers, frame counter, blink_phase, pipeline registers, pix_color and pix_valid SHALL all be 0; all sprites are therefore invisible until the first frame_start.
REQ-031 An rst pulse mid-frame SHALL take effect on the next edge and discard in-flight pixels.

Structure
REQ-032 A shared package SHALL hold the colour constants (WALL 12'hfff, BEAN 12'hff0, BLACK), the rotation encodings and the SPR_DIM/COLOR_W defaults.
REQ-033 The per-sprite hit and address logic SHALL be one sub-module, sprite_addr_gen, instantiated NUM_SPR times with generate.

Verification
REQ-034 Sprite 0 at (100,50), rot 10, ROM texel=address; coordinate (103,52) -> pix_color=67 two enabled cycles later.
REQ-035 Sprites 0 and 1 overlapping, sprite 0 texel=TRANSP, sprite 1 texel=12'h0f0 -> 12'h0f0; sprite 0 texel 12'hf00 -> 12'hf00.
REQ-036 is_wall=1 with sprite hit -> 12'hfff; over=1 -> 0 regardless of other inputs.
REQ-037 spr_x changed mid-frame -> output unchanged until after the next frame_start; sprite at x=630 -> col 0 shows background.
REQ-038 spr_blink=1, BLINK_FRAMES=2 -> sprite visible for frames 0-1, hidden for frames 2-3, visible for frames 4-5.
REQ-039 rst asserted mid-line -> next edge pix_color=0 and pix_valid=0; sprites hidden until frame_start.

Source files
------------

// File: rtl/sprite_compositor_pkg.sv
// Shared constants for the sprite compositor: colour keys, rotation codes and
// the default sprite geometry.
package sprite_compositor_pkg;

    localparam int SPR_DIM_DEF = 32;
    localparam int COLOR_W_DEF = 12;

    localparam logic [11:0] COLOR_WALL  = 12'hfff;
    localparam logic [11:0] COLOR_BEAN  = 12'hff0;
    localparam logic [11:0] COLOR_BLACK = 12'h000;

    // Orientation codes: the first term names the address major axis.
    typedef enum logic [1:0] {
        ROT_DX_DY   = 2'b00,
        ROT_DX_FLIP = 2'b01,
        ROT_DY_DX   = 2'b10,
        ROT_DY_FLIP = 2'b11
    } rot_e;

endpackage

// File: rtl/sprite_compositor_if.sv
// Pixel-stream, sprite-configuration and texel-ROM bundle of the compositor.
interface sprite_compositor_if #(
    parameter int NUM_SPR = 4,
    parameter int SPR_DIM = 32,
    parameter int COLOR_W = 12
) ();
    localparam int AW = 2 * $clog2(SPR_DIM);

    logic                      pix_en;
    logic [9:0]                col_addr;
    logic [8:0]                row_addr;
    logic                      frame_start;
    logic [NUM_SPR*10-1:0]     spr_x;
    logic [NUM_SPR*9-1:0]      spr_y;
    logic [NUM_SPR-1:0]        spr_en;
    logic [NUM_SPR-1:0]        spr_blink;
    logic [NUM_SPR*2-1:0]      spr_rot;
    logic                      is_wall;
    logic                      is_bean;
    logic                      over;
    logic [NUM_SPR*AW-1:0]     rom_addr;
    logic [NUM_SPR*COLOR_W-1:0] rom_data;
    logic [COLOR_W-1:0]        pix_color;
    logic                      pix_valid;

    modport master (
        output pix_en, col_addr, row_addr, frame_start, spr_x, spr_y, spr_en,
               spr_blink, spr_rot, is_wall, is_bean, over, rom_data,
        input  rom_addr, pix_color, pix_valid
    );

    modport slave (
        input  pix_en, col_addr, row_addr, frame_start, spr_x, spr_y, spr_en,
               spr_blink, spr_rot, is_wall, is_bean, over, rom_data,
        output rom_addr, pix_color, pix_valid
    );

endinterface

// File: rtl/sprite_compositor_addr.sv
// Per-sprite hit test and texel address generation for one raster coordinate.
module sprite_addr_gen
    import sprite_compositor_pkg::*;
#(
    parameter int SPR_DIM = SPR_DIM_DEF
) (
    input  logic [9:0]                    i_col,
    input  logic [8:0]                    i_row,
    input  logic [9:0]                    i_x,
    input  logic [8:0]                    i_y,
    input  logic                          i_en,
    input  logic                          i_hide,
    input  logic [1:0]                    i_rot,
    output logic                          o_hit,
    output logic [2*$clog2(SPR_DIM)-1:0]  o_addr
);
    localparam int LW = $clog2(SPR_DIM);

    logic signed [10:0] w_dx;
    logic signed [9:0]  w_dy;
    logic               w_in_x;
    logic               w_in_y;
    logic [LW-1:0]      w_dxl;
    logic [LW-1:0]      w_dyl;

    // One extra bit keeps a coordinate left of / above the sprite negative.
    assign w_dx   = $signed({1'b0, i_col}) - $signed({1'b0, i_x});
    assign w_dy   = $signed({1'b0, i_row}) - $signed({1'b0, i_y});
    assign w_in_x = !w_dx[10] && (w_dx[9:LW] == '0);
    assign w_in_y = !w_dy[9]  && (w_dy[8:LW] == '0);
    assign w_dxl  = w_dx[LW-1:0];
    assign w_dyl  = w_dy[LW-1:0];
    assign o_hit  = i_en && !i_hide && w_in_x && w_in_y;

    always_comb begin
        case (rot_e'(i_rot))
            ROT_DX_DY:   o_addr = {w_dxl, w_dyl};
            ROT_DX_FLIP: o_addr = {w_dxl, ~w_dyl};
            ROT_DY_DX:   o_addr = {w_dyl, w_dxl};
            default:     o_addr = {w_dyl, ~w_dxl};
        endcase
    end

endmodule

// File: rtl/sprite_compositor.sv
// Two-stage sprite compositor: shadowed sprite state, ROM address / hit stage,
// then priority colour selection over wall, sprites and bean.
module sprite_compositor
    import sprite_compositor_pkg::*;
#(
    parameter int                 NUM_SPR      = 4,
    parameter int                 SPR_DIM      = SPR_DIM_DEF,
    parameter int                 COLOR_W      = COLOR_W_DEF,
    parameter logic [COLOR_W-1:0] TRANSP       = '0,
    parameter int                 BLINK_FRAMES = 16
) (
    input logic                clk,
    input logic                rst,
    sprite_compositor_if.slave bus
);
    localparam int AW  = 2 * $clog2(SPR_DIM);
    localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [NUM_SPR*10-1:0] r_spr_x;
    logic [NUM_SPR*9-1:0]  r_spr_y;
    logic [NUM_SPR-1:0]    r_spr_en;
    logic [NUM_SPR-1:0]    r_spr_blink;
    logic [NUM_SPR*2-1:0]  r_spr_rot;
    logic [FCW-1:0]        r_fcnt;
    logic                  r_blink_phase;

    logic [NUM_SPR*AW-1:0] w_addr;
    logic [NUM_SPR-1:0]    w_hit;

    logic [NUM_SPR*AW-1:0] r_addr_p1;
    logic [NUM_SPR-1:0]    r_hit_p1;
    logic                  r_wall_p1, r_bean_p1, r_over_p1, r_vld_p1;

    logic                  w_spr_found;
    logic [COLOR_W-1:0]    w_spr_texel;
    logic [COLOR_W-1:0]    w_color;
    logic [COLOR_W-1:0]    r_color_p2;
    logic                  r_vld_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_spr_x       <= '0;
            r_spr_y       <= '0;
            r_spr_en      <= '0;
            r_spr_blink   <= '0;
            r_spr_rot     <= '0;
            r_fcnt        <= '0;
            r_blink_phase <= 1'b0;
        end else if (bus.frame_start) begin
            r_spr_x     <= bus.spr_x;
            r_spr_y     <= bus.spr_y;
            r_spr_en    <= bus.spr_en;
            r_spr_blink <= bus.spr_blink;
            r_spr_rot   <= bus.spr_rot;
            if (r_fcnt == FCW'(BLINK_FRAMES - 1)) begin
                r_fcnt        <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_fcnt <= r_fcnt + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_SPR; g++) begin : gen_spr
        sprite_addr_gen #(.SPR_DIM(SPR_DIM)) u_addr (
            .i_col  (bus.col_addr),
            .i_row  (bus.row_addr),
            .i_x    (r_spr_x[g*10 +: 10]),
            .i_y    (r_spr_y[g*9 +: 9]),
            .i_en   (r_spr_en[g]),
            .i_hide (r_spr_blink[g] & r_blink_phase),
            .i_rot  (r_spr_rot[g*2 +: 2]),
            .o_hit  (w_hit[g]),
            .o_addr (w_addr[g*AW +: AW])
        );
    end

    // While stalled the ROM keeps re-reading the stage-1 address so its data holds.
    assign bus.rom_addr = bus.pix_en ? w_addr : r_addr_p1;

    // Stage 1: address, hit vector and background flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr_p1 <= '0;
            r_hit_p1  <= '0;
            r_wall_p1 <= 1'b0;
            r_bean_p1 <= 1'b0;
            r_over_p1 <= 1'b0;
            r_vld_p1  <= 1'b0;
        end else if (bus.pix_en) begin
            r_addr_p1 <= w_addr;
            r_hit_p1  <= w_hit;
            r_wall_p1 <= bus.is_wall;
            r_bean_p1 <= bus.is_bean;
            r_over_p1 <= bus.over;
            r_vld_p1  <= 1'b1;
        end
    end

    always_comb begin
        w_spr_found = 1'b0;
        w_spr_texel = '0;
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            if (r_hit_p1[i] && (bus.rom_data[i*COLOR_W +: COLOR_W] != TRANSP)) begin
                w_spr_found = 1'b1;
                w_spr_texel = bus.rom_data[i*COLOR_W +: COLOR_W];
            end
        end
        if (r_over_p1)        w_color = COLOR_W'(COLOR_BLACK);
        else if (r_wall_p1)   w_color = COLOR_W'(COLOR_WALL);
        else if (w_spr_found) w_color = w_spr_texel;
        else if (r_bean_p1)   w_color = COLOR_W'(COLOR_BEAN);
        else                  w_color = COLOR_W'(COLOR_BLACK);
    end

    // Stage 2: composited colour
    always_ff @(posedge clk) begin
        if (rst) begin
            r_color_p2 <= '0;
            r_vld_p2   <= 1'b0;
        end else if (bus.pix_en) begin
            r_color_p2 <= w_color;
            r_vld_p2   <= r_vld_p1;
        end
    end

    assign bus.pix_color = r_color_p2;
    assign bus.pix_valid = r_vld_p2;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed scoreboard bench for sprite_compositor with a behavioural texel ROM.
module tb_sprite_compositor;
    localparam int NS  = 4;
    localparam int DIM = 32;
    localparam int CW  = 12;
    localparam int BF  = 2;
    localparam int AW  = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sprite_compositor_if #(.NUM_SPR(NS), .SPR_DIM(DIM), .COLOR_W(CW)) bus ();

    sprite_compositor #(
        .NUM_SPR(NS), .SPR_DIM(DIM), .COLOR_W(CW),
        .TRANSP(12'h000), .BLINK_FRAMES(BF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    int         m_x [NS];
    int         m_y [NS];
    bit         m_en [NS];
    bit         m_blink [NS];
    bit [1:0]   m_rot [NS];
    int         fcount;
    bit         rom_mode [NS];
    logic [11:0] rom_const [NS];

    logic [11:0] q[$];
    logic [11:0] last_exp;
    int          en_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] tex(input int i, input int addr);
        return rom_mode[i] ? rom_const[i] : 12'(addr);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < NS; i++)
            bus.rom_data[i*CW +: CW] <= tex(i, int'(bus.rom_addr[i*AW +: AW]));
    end

    function automatic logic [11:0] model(input int col, input int row,
                                          input bit wall, input bit bean, input bit ovr);
        bit phase;
        int dx, dy, a;
        logic [11:0] t;
        phase = ((fcount / BF) % 2) == 1;
        if (ovr) return 12'h000;
        if (wall) return 12'hfff;
        for (int i = 0; i < NS; i++) begin
            dx = col - m_x[i];
            dy = row - m_y[i];
            if (m_en[i] && !(m_blink[i] && phase) &&
                dx >= 0 && dx < DIM && dy >= 0 && dy < DIM) begin
                case (m_rot[i])
                    2'd0:    a = dx * DIM + dy;
                    2'd1:    a = dx * DIM + (DIM - 1 - dy);
                    2'd2:    a = dy * DIM + dx;
                    default: a = dy * DIM + (DIM - 1 - dx);
                endcase
                t = tex(i, a);
                if (t != 12'h000) return t;
            end
        end
        if (bean) return 12'hff0;
        return 12'h000;
    endfunction

    task automatic latch();
        for (int i = 0; i < NS; i++) begin
            m_x[i]     = int'(bus.spr_x[i*10 +: 10]);
            m_y[i]     = int'(bus.spr_y[i*9 +: 9]);
            m_en[i]    = bus.spr_en[i];
            m_blink[i] = bus.spr_blink[i];
            m_rot[i]   = bus.spr_rot[i*2 +: 2];
        end
        fcount++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_x[i] = 0; m_y[i] = 0; m_en[i] = 0; m_blink[i] = 0; m_rot[i] = 0;
        end
        fcount = 0;
    endtask

    task automatic set_spr(input int i, input int x, input int y,
                           input bit en, input bit blink, input int rot);
        bus.spr_x[i*10 +: 10] = 10'(x);
        bus.spr_y[i*9 +: 9]   = 9'(y);
        bus.spr_en[i]         = en;
        bus.spr_blink[i]      = blink;
        bus.spr_rot[i*2 +: 2] = 2'(rot);
    endtask

    task automatic pixel(input int col, input int row, input bit wall = 0,
                         input bit bean = 0, input bit ovr = 0, input bit fs = 0);
        bus.col_addr    = 10'(col);
        bus.row_addr    = 9'(row);
        bus.is_wall     = wall;
        bus.is_bean     = bean;
        bus.over        = ovr;
        bus.frame_start = fs;
        bus.pix_en      = 1'b1;
        q.push_back(model(col, row, wall, bean, ovr));
        if (fs) latch();
        @(posedge clk); #1;
        bus.pix_en      = 1'b0;
        bus.frame_start = 1'b0;
    endtask

    task automatic fstart();
        bus.pix_en      = 1'b0;
        bus.frame_start = 1'b1;
        latch();
        @(posedge clk); #1;
        bus.frame_start = 1'b0;
    endtask

    task automatic stall(input int n);
        bus.pix_en = 1'b0;
        for (int k = 0; k < n; k++) begin
            bus.col_addr = 10'($urandom_range(0, 639));
            bus.row_addr = 9'($urandom_range(0, 479));
            bus.is_wall  = 1'($urandom);
            bus.over     = 1'($urandom);
            @(posedge clk); #1;
            check("hold_color", bus.pix_color, last_exp);
            check("hold_valid", bus.pix_valid, 1);
        end
        bus.is_wall = 1'b0;
        bus.over    = 1'b0;
    endtask

    task automatic do_reset();
        bus.pix_en = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_color", bus.pix_color, 0);
        check("midrst_valid", bus.pix_valid, 0);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        en_cnt   = 0;
        last_exp = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                q.delete();
                en_cnt = 0;
            end else if (bus.pix_en) begin
                #1;
                en_cnt++;
                check("valid", bus.pix_valid, (en_cnt >= 2) ? 1 : 0);
                if (bus.pix_valid) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $error("FAIL scoreboard_empty observed=0x%0h expected=none", bus.pix_color);
                    end else begin
                        last_exp = q.pop_front();
                        check("pix_color", bus.pix_color, last_exp);
                    end
                end
            end
        end
    end

    initial begin
        bus.pix_en = 0; bus.col_addr = 0; bus.row_addr = 0; bus.frame_start = 0;
        bus.spr_x = '0; bus.spr_y = '0; bus.spr_en = '0; bus.spr_blink = '0;
        bus.spr_rot = '0; bus.is_wall = 0; bus.is_bean = 0; bus.over = 0;
        for (int i = 0; i < NS; i++) begin
            rom_mode[i] = 0;
            rom_const[i] = '0;
        end
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check("rst_color", bus.pix_color, 0);
        check("rst_valid", bus.pix_valid, 0);
        rst = 1'b0;

        // Sprites stay invisible until the first frame_start.
        set_spr(0, 100, 50, 1, 0, 2);
        pixel(103, 52);
        pixel(103, 52, 0, 1);
        fstart();
        pixel(103, 52);
        pixel(100, 50, 0, 1);
        pixel(131, 81);
        pixel(132, 52, 0, 1);
        pixel(99, 52, 0, 1);
        pixel(103, 49);

        for (int r = 0; r < 4; r++) begin
            set_spr(0, 100, 50, 1, 0, r);
            fstart();
            pixel(103, 52);
            pixel(110, 70);
        end

        // Overlap priority and transparent fall-through.
        set_spr(0, 100, 50, 1, 0, 2);
        set_spr(1, 100, 50, 1, 0, 0);
        fstart();
        pixel(1000, 500);
        rom_mode[0] = 1; rom_const[0] = 12'h000;
        rom_mode[1] = 1; rom_const[1] = 12'h0f0;
        pixel(105, 60);
        pixel(140, 60, 0, 1);
        pixel(1000, 500);
        rom_const[0] = 12'hf00;
        pixel(105, 60);
        pixel(105, 60, 1, 1, 0);
        pixel(105, 60, 1, 1, 1);
        pixel(1000, 500);
        rom_const[0] = 12'h000; rom_const[1] = 12'h000;
        pixel(105, 60, 0, 1);
        pixel(1000, 500);
        rom_mode[0] = 0; rom_mode[1] = 0;

        // Mid-frame changes are ignored until the next frame_start.
        set_spr(1, 0, 0, 0, 0, 0);
        fstart();
        set_spr(0, 300, 200, 1, 0, 2);
        pixel(103, 52);
        pixel(303, 202, 0, 1);
        stall(3);
        pixel(103, 52);
        fstart();
        pixel(103, 52, 0, 1);
        pixel(303, 202);

        // Screen-edge sprite: no wrap to column/row 0.
        set_spr(0, 630, 470, 1, 0, 2);
        fstart();
        pixel(0, 472, 0, 1);
        pixel(639, 472);
        pixel(635, 0, 0, 1);
        pixel(635, 479);

        // frame_start coinciding with a pixel uses the old shadow values.
        set_spr(0, 100, 50, 1, 0, 2);
        pixel(103, 52, 0, 1, 0, 1);
        pixel(103, 52);
        stall(4);
        pixel(104, 52);

        set_spr(0, 100, 50, 1, 1, 2);
        for (int k = 0; k < 5; k++) begin
            fstart();
            pixel(103, 52, 0, 1);
            pixel(1000, 500);
        end

        pixel(103, 52);
        pixel(104, 52);
        do_reset();
        pixel(103, 52, 0, 1);
        pixel(104, 52);
        fstart();
        pixel(103, 52);
        pixel(1000, 500);
        #2;
        check("drain", q.size(), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
